// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
//
// Round-robin arbiter that shares one SPI transaction engine among NUM_REQ
// requesters. The winner's word is latched and presented to the engine while
// the level-held xfer_start is high. The received word is returned to the
// winner with a one-cycle done pulse. The engine is then held in reset for at
// least one RELEASE cycle before the next grant can be issued.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a RUN-state watchdog aborts a transaction that has not
//   completed after TIMEOUT_CYCLES cycles and pulses timeout_err. When it is
//   not defined, RUN waits indefinitely and timeout_err is tied low.
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   DATA_W         SPI word width
//   TIMEOUT_CYCLES RUN-state watchdog limit (only with SPI_ARB_TIMEOUT_EN)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous, active-low reset
//   req           in   level request per requester
//   req_data      in   packed words, requester i at [i*DATA_W +: DATA_W]
//   grant         out  one-hot grant, high for the whole RUN period
//   done          out  one-hot 1-cycle completion pulse
//   rsp_data      out  received word, valid with done, held until next done
//   timeout_err   out  1-cycle watchdog abort pulse
//   xfer_start    out  engine run level (0 holds the engine in reset)
//   xfer_data     out  word to transmit, stable while xfer_start is high
//   xfer_sel      out  one-hot slave select, equal to grant
//   xfer_complete in   engine completion flag
//   xfer_rdata    in   engine received word, valid with xfer_complete
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      timeout_err,
  output logic                      xfer_start,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [NUM_REQ-1:0]        xfer_sel,
  input  logic                      xfer_complete,
  input  logic [DATA_W-1:0]         xfer_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration time.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("spi_txn_arbiter: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       last_reg;
  logic [NUM_REQ-1:0]     grant_reg;
  logic [NUM_REQ-1:0]     done_reg;
  logic [DATA_W-1:0]      rsp_reg;
  logic                   start_reg;
  logic [DATA_W-1:0]      xdata_reg;
  logic [IDX_W-1:0]       win_reg;

  // Unpack the flat request bus into one word per requester.
  logic [DATA_W-1:0] req_word [NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: candidates are visited from the farthest offset
  // down to offset 1, so the nearest set bit after last_reg is the one that
  // remains selected when the loop ends.
  logic                   pick_valid_next;
  logic [IDX_W-1:0]       pick_idx_next;
  logic [IDX_W-1:0]       cand_next;
  logic [NUM_REQ-1:0]     pick_onehot_next;

  always_comb begin
    pick_valid_next = 1'b0;
    pick_idx_next   = '0;
    cand_next       = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_next = IDX_W'((int'(last_reg) + off) % NUM_REQ);
      if (req[cand_next]) begin
        pick_valid_next = 1'b1;
        pick_idx_next   = cand_next;
      end
    end
    pick_onehot_next = NUM_REQ'(1) << pick_idx_next;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      last_reg  <= IDX_W'(NUM_REQ - 1);
      win_reg   <= '0;
      grant_reg <= '0;
      done_reg  <= '0;
      rsp_reg   <= '0;
      start_reg <= 1'b0;
      xdata_reg <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      // Pulses default low every cycle.
      done_reg <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (pick_valid_next) begin
            win_reg   <= pick_idx_next;
            grant_reg <= pick_onehot_next;
            xdata_reg <= req_word[pick_idx_next];
            start_reg <= 1'b1;
            state_reg <= S_RUN;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end

        S_RUN: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (xfer_complete) begin
            rsp_reg   <= xfer_rdata;
            done_reg  <= grant_reg;
            grant_reg <= '0;
            start_reg <= 1'b0;
            xdata_reg <= '0;
            last_reg  <= win_reg;
            state_reg <= S_RELEASE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th RUN cycle without completion.
            timeout_reg <= 1'b1;
            grant_reg   <= '0;
            start_reg   <= 1'b0;
            xdata_reg   <= '0;
            last_reg    <= win_reg;
            state_reg   <= S_RELEASE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end

        S_RELEASE: begin
          // Engine stays in reset here; requests are not looked at.
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_reg;
  assign xfer_sel   = grant_reg;
  assign done       = done_reg;
  assign rsp_data   = rsp_reg;
  assign xfer_start = start_reg;
  assign xfer_data  = xdata_reg;

`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_err = timeout_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
//
// Scoreboard bench for spi_txn_arbiter. Expected grants are queued when the
// stimulus raises requests; a monitor pops them on each grant and checks the
// RUN period, the done pulse, rsp_data and the idle gap. A simple engine model
// completes each transfer after eng_lat cycles and returns xfer_data ^ 0x99.
// Define SPI_ARB_TIMEOUT_EN to include the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_CYC  = 16;
`else
  localparam int TO_CYC  = 1024;
`endif

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_data;
  logic                      timeout_err;
  logic                      xfer_start;
  logic [DATA_W-1:0]         xfer_data;
  logic [NUM_REQ-1:0]        xfer_sel;
  logic                      xfer_complete;
  logic [DATA_W-1:0]         xfer_rdata;

  spi_txn_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .done         (done),
    .rsp_data     (rsp_data),
    .timeout_err  (timeout_err),
    .xfer_start   (xfer_start),
    .xfer_data    (xfer_data),
    .xfer_sel     (xfer_sel),
    .xfer_complete(xfer_complete),
    .xfer_rdata   (xfer_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] grant;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          active;
  int          n_checks;
  int          n_fail;
  int          n_to;
  logic [7:0]  last_rsp;
  logic [2:0]  prev_done;
  logic [7:0]  dword [3];
  bit          eng_en;
  int          eng_lat;
  int          eng_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int idx);
    exp_t e;
    e.grant = 3'(1 << idx);
    e.wdata = dword[idx];
    e.rdata = dword[idx] ^ 8'h99;
    return e;
  endfunction

  task automatic set_data();
    req_data = {dword[2], dword[1], dword[0]};
  endtask

  task automatic wait_dones(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done != 0) seen++;
    end
    if (seen < n) check_eq("wait_done", seen, n);
  endtask

  task automatic wait_grant(input int budget);
    int cyc = 0;
    while (grant == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (grant == 0) check_eq("wait_grant", grant, 3'b111);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_grant"},       grant,       0);
    check_eq({pfx, "_done"},        done,        0);
    check_eq({pfx, "_rsp_data"},    rsp_data,    0);
    check_eq({pfx, "_timeout_err"}, timeout_err, 0);
    check_eq({pfx, "_xfer_start"},  xfer_start,  0);
    check_eq({pfx, "_xfer_data"},   xfer_data,   0);
    check_eq({pfx, "_xfer_sel"},    xfer_sel,    0);
  endtask

  // Engine model: counts RUN cycles and raises xfer_complete for one cycle.
  initial begin
    xfer_complete = 1'b0;
    xfer_rdata    = '0;
    eng_cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      xfer_complete = 1'b0;
      xfer_rdata    = 8'($urandom);
      if (!xfer_start) begin
        eng_cnt = 0;
      end else if (eng_en) begin
        eng_cnt++;
        if (eng_cnt == eng_lat) begin
          xfer_complete = 1'b1;
          xfer_rdata    = xfer_data ^ 8'h99;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    active    = 1'b0;
    prev_done = '0;
    last_rsp  = '0;
    n_to      = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active    = 1'b0;
        prev_done = '0;
        last_rsp  = '0;
      end else begin
        check_eq("grant_onehot", 32'($onehot0(grant)), 1);
        if (prev_done != 0) check_eq("gap_start", xfer_start, 0);
        if (active && grant == 0) begin
          active = 1'b0;
          if (timeout_err) begin
            n_to++;
`ifndef SPI_ARB_TIMEOUT_EN
            check_eq("timeout_err_tied", timeout_err, 0);
`endif
            check_eq("to_no_done", done, 0);
            check_eq("to_rsp_hold", rsp_data, last_rsp);
            $display("txn timeout grant=%b", cur.grant);
          end else begin
            check_eq("done", done, cur.grant);
            check_eq("rsp_data", rsp_data, cur.rdata);
            check_eq("done_start_low", xfer_start, 0);
            last_rsp = cur.rdata;
            $display("txn done grant=%b wdata=%h rsp=%h", cur.grant, cur.wdata, rsp_data);
          end
        end else begin
          check_eq("spurious_done", done, 0);
          check_eq("spurious_timeout", timeout_err, 0);
        end
        if (grant != 0) begin
          if (!active) begin
            if (exp_q.size() == 0) begin
              check_eq("unexpected_grant", grant, 0);
            end else begin
              cur    = exp_q.pop_front();
              active = 1'b1;
            end
          end
          if (active) begin
            check_eq("grant",      grant,      cur.grant);
            check_eq("xfer_sel",   xfer_sel,   cur.grant);
            check_eq("xfer_data",  xfer_data,  cur.wdata);
            check_eq("xfer_start", xfer_start, 1);
          end
        end
        prev_done = done;
      end
    end
  end

  // Global safety net.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected $finish before time limit");
    $fatal(1, "simulation time limit");
  end

  // Stimulus.
  initial begin
    int ord2 [6];
    int run;
    int cyc;
    ord2     = '{0, 1, 2, 0, 1, 2};
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    req      = '0;
    eng_en   = 1'b1;
    eng_lat  = 20;
    dword    = '{8'hA5, 8'h5A, 8'hC3};
    set_data();

    // Reset values.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single transaction, requester 0, 20-cycle engine.
    exp_q.push_back(mk(0));
    req = 3'b001;
    wait_dones(1, 100);
    req = '0;
    eng_lat = 4;

    // Requester 2 alone, so the pointer ends on 2.
    exp_q.push_back(mk(2));
    req = 3'b100;
    wait_dones(1, 50);
    req = '0;

    // All three held: strict rotation over six transactions.
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(ord2[i]));
    req = 3'b111;
    wait_dones(6, 300);
    req = '0;

    // Pointer on 1, then 101: wrap search gives 2 then 0.
    exp_q.push_back(mk(1));
    req = 3'b010;
    wait_dones(1, 50);
    req = '0;
    exp_q.push_back(mk(2));
    exp_q.push_back(mk(0));
    req = 3'b101;
    wait_dones(2, 100);
    req = '0;

    // Requester 1 drops req and changes its word mid-RUN.
    eng_lat = 10;
    exp_q.push_back(mk(1));
    req = 3'b010;
    wait_grant(20);
    repeat (3) @(negedge clk);
    req = '0;
    req_data[15:8] = 8'hEE;
    wait_dones(1, 50);
    set_data();

    // Reset five cycles into RUN aborts without done.
    eng_lat = 20;
    exp_q.push_back(mk(2));
    req = 3'b100;
    wait_grant(20);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b1;

    // Pointer is back at NUM_REQ-1: 110 serves 1 before 2.
    eng_lat = 4;
    exp_q.push_back(mk(1));
    exp_q.push_back(mk(2));
    req = 3'b110;
    wait_dones(2, 100);
    req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine never completes: watchdog fires on the 16th RUN cycle.
    repeat (3) @(negedge clk);
    eng_en = 1'b0;
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(1));
    req = 3'b011;
    wait_grant(20);
    run = 0;
    cyc = 0;
    while (cyc < 100 && !timeout_err) begin
      if (grant != 0) run++;
      @(negedge clk);
      cyc++;
    end
    check_eq("to_run_cycles", run, TO_CYC);
    check_eq("to_pulse", timeout_err, 1);
    check_eq("to_done_low", done, 0);
    eng_en = 1'b1;
    @(negedge clk);
    check_eq("to_release_grant", grant, 0);
    check_eq("to_pulse_width", timeout_err, 0);
    @(negedge clk);
    check_eq("to_next_grant", grant, 3'b010);
    wait_dones(1, 50);
    req = '0;
    check_eq("to_count", n_to, 1);
`endif

    repeat (5) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
